layer_5_maxpool_2x2: RTL and testbench

Streaming 2x2, stride-2 max-pooling stage. It consumes the raster-ordered FP32 pixel stream of one layer-4 output feature map, after channel summation, bias and leaky ReLU. It emits the pooled map at half resolution in each dimension. One instance sits downstream of each layer_4_featuremap_N and feeds the layer-6 convolution inputs.

---
 rtl/layer_5_maxpool_2x2_pkg.sv | 15 +
 rtl/layer_5_maxpool_2x2_fp32_max2.sv | 20 ++
 rtl/layer_5_maxpool_2x2.sv | 97 +++++++++
 tb/tb_layer_5_maxpool_2x2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_5_maxpool_2x2_pkg.sv
// Shared FP32 helpers for the layer-5 2x2 max-pooling stage: pixel width,
// total-order key for IEEE-754 single values, and signed-zero constants.
package layer_5_maxpool_2x2_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [31:0] ZERO     = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

  // Monotonic unsigned key: -inf < negatives < -0 < +0 < positives < +inf.
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/layer_5_maxpool_2x2_fp32_max2.sv
// Combinational FP32 maximum of two operands; i_a (the earlier-arriving
// operand) wins when the keys are equal.
module fp32_max2
  import layer_5_maxpool_2x2_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_max
);

  logic [31:0] w_key_a;
  logic [31:0] w_key_b;

  always_comb begin
    w_key_a = fp32_key(i_a);
    w_key_b = fp32_key(i_b);
    o_max   = (w_key_b > w_key_a) ? i_b : i_a;
  end

endmodule

// File: rtl/layer_5_maxpool_2x2.sv
// Streaming 2x2 stride-2 FP32 max-pool over a raster-ordered square map;
// top-row pair maxima are parked in a half-width row buffer.
module layer_5_maxpool_2x2 #(
  parameter int unsigned DATA_WIDTH = layer_5_maxpool_2x2_pkg::DATA_WIDTH,
  parameter int unsigned IMG_SIZE   = 104
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int unsigned CW   = $clog2(IMG_SIZE);
  localparam int unsigned HALF = IMG_SIZE / 2;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_rowbuf [HALF];

  logic [CW-2:0]         w_half;
  logic [DATA_WIDTH-1:0] w_rowbuf_rd;
  logic [DATA_WIDTH-1:0] w_top_max;
  logic [DATA_WIDTH-1:0] w_bot_max;
  logic [DATA_WIDTH-1:0] w_win_max;
  logic                  w_wr;
  logic                  w_trig;
  logic                  w_last;

  always_comb begin
    w_half      = r_col[CW-1:1];
    w_rowbuf_rd = r_rowbuf[w_half];
    w_wr        = valid_in && !Rst && r_col[0] && !r_row[0];
    w_trig      = valid_in && r_col[0] && r_row[0];
    w_last      = (r_col == LAST) && (r_row == LAST);
  end

  // Separate top/bottom pair comparators keep the write and read paths independent.
  fp32_max2 u_top_max (
    .i_a   (r_hold),
    .i_b   (data_in),
    .o_max (w_top_max)
  );

  fp32_max2 u_bot_max (
    .i_a   (r_hold),
    .i_b   (data_in),
    .o_max (w_bot_max)
  );

  fp32_max2 u_win_max (
    .i_a   (w_rowbuf_rd),
    .i_b   (w_bot_max),
    .o_max (w_win_max)
  );

  always_ff @(posedge Clk) begin
    if (w_wr) begin
      r_rowbuf[w_half] <= w_top_max;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_hold     <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!r_col[0]) begin
          r_hold <= data_in;
        end
        if (w_trig) begin
          data_out   <= w_win_max;
          valid_out  <= 1'b1;
          frame_done <= w_last;
        end
        if (r_col == LAST) begin
          r_col <= '0;
          r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_5_maxpool_2x2.sv
// Self-checking bench: table-driven 4x4 frames plus gap/reset sequences on a
// small instance, and back-to-back random frames on a full-size instance.
module tb_layer_5_maxpool_2x2;

  localparam int unsigned BIG = 104;

  typedef struct {
    logic [31:0] p [4];
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          due;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst4 = 1'b1, rst104 = 1'b1;
  logic [31:0] d4 = '0, d104 = '0;
  logic        v4 = 1'b0, v104 = 1'b0;
  logic [31:0] do4, do104;
  logic        vo4, vo104, fd4, fd104;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fd4_cnt = 0;
  int fd104_cnt = 0;

  sb_t  q4[$];
  sb_t  q104[$];
  vec_t tbl [8];
  logic [31:0] fr104 [0:2*BIG*BIG-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_5_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(4)) dut4 (
    .Clk(clk), .Rst(rst4), .data_in(d4), .valid_in(v4),
    .data_out(do4), .valid_out(vo4), .frame_done(fd4)
  );

  layer_5_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(BIG)) dut104 (
    .Clk(clk), .Rst(rst104), .data_in(d104), .valid_in(v104),
    .data_out(do104), .valid_out(vo104), .frame_done(fd104)
  );

  // Independent ordering model: map to a signed integer where -0 sits just below +0.
  function automatic longint ord(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? (-m - 1) : m;
  endfunction

  function automatic logic [31:0] rnd_fp(input logic [31:0] prev);
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: x = 32'h0000_0000;
      1: x = 32'h8000_0000;
      2: x = prev;
      default: ;
    endcase
    if (x[30:23] == 8'hff) x[22:0] = '0;
    return x;
  endfunction

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input logic [31:0] e);
    tbl[i].p[0] = a; tbl[i].p[1] = b; tbl[i].p[2] = c; tbl[i].p[3] = d;
    tbl[i].exp  = e;
  endtask

  task automatic idle4(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      v4 = 1'b0;
      d4 = 32'hdead_beef;
    end
  endtask

  // Drives pixel (r,c) of 4x4 frame f; pushes the expected window result on its trigger pixel.
  task automatic send4(input int f, input int r, input int c);
    int idx;
    idx = f * 4 + (r / 2) * 2 + (c / 2);
    @(posedge clk); #1;
    d4 = tbl[idx].p[(r % 2) * 2 + (c % 2)];
    v4 = 1'b1;
    if ((r % 2 == 1) && (c % 2 == 1))
      q4.push_back('{data: tbl[idx].exp, last: (r == 3 && c == 3), due: cyc + 1});
  endtask

  always @(negedge clk) begin : mon4
    sb_t e;
    while (q4.size() > 0 && q4[0].due < cyc) begin
      checks++; failures++;
      $display("FAIL out4_missing got=none expected=%h due=%0d now=%0d", q4[0].data, q4[0].due, cyc);
      void'(q4.pop_front());
    end
    if (fd4) fd4_cnt++;
    if (vo4) begin
      checks++;
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL out4_unexpected got=%h fd=%b expected=none cyc=%0d", do4, fd4, cyc);
      end else begin
        e = q4.pop_front();
        if (do4 !== e.data || fd4 !== e.last || cyc != e.due) begin
          failures++;
          $display("FAIL out4_data got=%h fd=%b cyc=%0d expected=%h fd=%b cyc=%0d",
                   do4, fd4, cyc, e.data, e.last, e.due);
        end
      end
    end else if (fd4) begin
      checks++; failures++;
      $display("FAIL fd4_alone got=1 expected=0 cyc=%0d", cyc);
    end
  end

  always @(negedge clk) begin : mon104
    sb_t e;
    while (q104.size() > 0 && q104[0].due < cyc) begin
      checks++; failures++;
      $display("FAIL out104_missing got=none expected=%h due=%0d now=%0d", q104[0].data, q104[0].due, cyc);
      void'(q104.pop_front());
    end
    if (fd104) fd104_cnt++;
    if (vo104) begin
      checks++;
      if (q104.size() == 0) begin
        failures++;
        $display("FAIL out104_unexpected got=%h expected=none cyc=%0d", do104, cyc);
      end else begin
        e = q104.pop_front();
        if (do104 !== e.data || fd104 !== e.last || cyc != e.due) begin
          failures++;
          $display("FAIL out104_data got=%h fd=%b cyc=%0d expected=%h fd=%b cyc=%0d",
                   do104, fd104, cyc, e.data, e.last, e.due);
        end
      end
    end else if (fd104) begin
      checks++; failures++;
      $display("FAIL fd104_alone got=1 expected=0 cyc=%0d", cyc);
    end
  end

  initial begin
    // Frame 0: the 1..16 ramp; frame 1: sign/zero, tie and infinity corner windows.
    set_vec(0, 32'h3f800000, 32'h40000000, 32'h40a00000, 32'h40c00000, 32'h40c00000);
    set_vec(1, 32'h40400000, 32'h40800000, 32'h40e00000, 32'h41000000, 32'h41000000);
    set_vec(2, 32'h41100000, 32'h41200000, 32'h41500000, 32'h41600000, 32'h41600000);
    set_vec(3, 32'h41300000, 32'h41400000, 32'h41700000, 32'h41800000, 32'h41800000);
    set_vec(4, 32'hbf800000, 32'hc0000000, 32'h80000000, 32'hbf000000, 32'h80000000);
    set_vec(5, 32'h80000000, 32'h00000000, 32'hc0000000, 32'hc0000000, 32'h00000000);
    set_vec(6, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000);
    set_vec(7, 32'hff800000, 32'h7f800000, 32'h7f7fffff, 32'h00000001, 32'h7f800000);

    begin
      logic [31:0] prev;
      prev = 32'h3f80_0000;
      for (int i = 0; i < 2 * BIG * BIG; i++) begin
        fr104[i] = rnd_fp(prev);
        prev = fr104[i];
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (do4 !== 32'h0)   begin failures++; $display("FAIL rst4_data got=%h expected=0", do4); end
    checks++; if (vo4 !== 1'b0)    begin failures++; $display("FAIL rst4_valid got=%b expected=0", vo4); end
    checks++; if (fd4 !== 1'b0)    begin failures++; $display("FAIL rst4_fd got=%b expected=0", fd4); end
    checks++; if (do104 !== 32'h0) begin failures++; $display("FAIL rst104_data got=%h expected=0", do104); end
    checks++; if (vo104 !== 1'b0)  begin failures++; $display("FAIL rst104_valid got=%b expected=0", vo104); end
    @(posedge clk); #1;
    rst4 = 1'b0; rst104 = 1'b0;

    // Table frames back-to-back with continuous valid.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          send4(f, r, c);
    idle4(3);

    // Gapped frame: valid toggles every cycle, plus a 7-cycle gap mid row 1.
    for (int i = 0; i < 16; i++) begin
      send4(0, i / 4, i % 4);
      idle4((i == 5) ? 7 : 1);
    end
    idle4(3);

    // Partial frame cut by reset at (3,1); that pixel is dropped with Rst.
    for (int i = 0; i < 13; i++) send4(1, i / 4, i % 4);
    @(posedge clk); #1;
    rst4 = 1'b1; v4 = 1'b1; d4 = tbl[7].p[2];
    idle4(1);
    @(posedge clk); #1;
    rst4 = 1'b0;
    v4 = 1'b0;
    idle4(2);
    for (int i = 0; i < 16; i++) send4(0, i / 4, i % 4);
    idle4(4);

    // Two full-size random frames with no idle cycle between them.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < int'(BIG); r++)
        for (int c = 0; c < int'(BIG); c++) begin
          int base;
          base = f * BIG * BIG;
          @(posedge clk); #1;
          d104 = fr104[base + r * BIG + c];
          v104 = 1'b1;
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            logic [31:0] m;
            logic [31:0] w [4];
            w[0] = fr104[base + (r - 1) * BIG + c - 1];
            w[1] = fr104[base + (r - 1) * BIG + c];
            w[2] = fr104[base + r * BIG + c - 1];
            w[3] = fr104[base + r * BIG + c];
            m = w[0];
            for (int k = 1; k < 4; k++)
              if (ord(w[k]) > ord(m)) m = w[k];
            q104.push_back('{data: m, last: (r == BIG - 1 && c == BIG - 1), due: cyc + 1});
          end
        end
    @(posedge clk); #1;
    v104 = 1'b0;
    idle4(5);

    checks++;
    if (q4.size() != 0) begin failures++; $display("FAIL q4_drain got=%0d expected=0", q4.size()); end
    checks++;
    if (q104.size() != 0) begin failures++; $display("FAIL q104_drain got=%0d expected=0", q104.size()); end
    checks++;
    if (fd4_cnt != 4) begin failures++; $display("FAIL fd4_count got=%0d expected=4", fd4_cnt); end
    checks++;
    if (fd104_cnt != 2) begin failures++; $display("FAIL fd104_count got=%0d expected=2", fd104_cnt); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
